// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing receiver.
package video_timing_pkg;

   localparam int CORDW_DEF = 16;

   localparam logic POL_NEG = 1'b0;
   localparam logic POL_POS = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/video_timing_rx_sync_edge.sv
// One-bit input register with a previous-value register; rise/fall compare the two.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= 1'b0;
         prev <= 1'b0;
      end else begin
         q    <= d;
         prev <= q;
      end
   end

   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/video_timing_rx.sv
// Recovers coordinates, strobes and sync polarity from an hsync/vsync/de stream,
// measures active size per frame and reports lock against the expected resolution.
module video_timing_rx
   import video_timing_pkg::*;
#(
   parameter int CORDW       = CORDW_DEF,
   parameter int H_RES       = 800,
   parameter int V_RES       = 600,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix,
   input  logic                    hsync,
   input  logic                    vsync,
   input  logic                    de,
   output logic                    de_o,
   output logic                    frame,
   output logic                    line,
   output logic signed [CORDW-1:0] sx,
   output logic signed [CORDW-1:0] sy,
   output logic                    h_pol,
   output logic                    v_pol,
   output logic signed [CORDW-1:0] h_act,
   output logic signed [CORDW-1:0] v_act,
   output logic                    locked
);

   localparam logic [CORDW-1:0] CMAX  = {1'b0, {(CORDW-1){1'b1}}};
   localparam logic [CORDW-1:0] ONE   = CORDW'(1);
   localparam logic [CORDW-1:0] H_EXP = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_EXP = CORDW'(V_RES);
   localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

   function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
      return (v == CMAX) ? v : v + ONE;
   endfunction

   logic hs_s1;
   logic vs_s1, vs_rise, vs_fall;
   logic de_s1, de_rise, de_fall;

   // hsync only contributes its level (polarity sampling); its edges are not needed.
   sync_edge u_hs (.clk(clk_pix), .rst(rst_pix), .d(hsync), .q(hs_s1), .rise(), .fall());
   sync_edge u_vs (.clk(clk_pix), .rst(rst_pix), .d(vsync), .q(vs_s1), .rise(vs_rise), .fall(vs_fall));
   sync_edge u_de (.clk(clk_pix), .rst(rst_pix), .d(de), .q(de_s1), .rise(de_rise), .fall(de_fall));

   state_t state_q, state_d;

   logic [CORDW-1:0] pix_cnt;
   logic [CORDW-1:0] line_cnt;
   logic [3:0]       lock_cnt;
   logic             first_line;
   logic             line_bad;

   logic       vs_edge;
   logic       run_now;
   logic       check_frame;
   logic       line_bad_now;
   logic       frame_ok;
   logic       pol_change;
   logic [3:0] lock_inc;

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && vs_edge) state_d = RUN;
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      vs_edge      = (v_pol == POL_POS) ? vs_rise : vs_fall;
      // An edge seen while IDLE already counts as running, so a coincident de rise is frame start.
      run_now      = (state_q == RUN) | vs_edge;
      check_frame  = (state_q == RUN) & vs_edge;
      line_bad_now = de_fall & ((pix_cnt != H_EXP) | (pix_cnt == CMAX));
      frame_ok     = !line_bad && !line_bad_now && (line_cnt == V_EXP) && (line_cnt != CMAX);
      pol_change   = de_rise & (((~hs_s1) != h_pol) | ((~vs_s1) != v_pol));
      lock_inc     = (lock_cnt >= LOCK_N) ? LOCK_N : lock_cnt + 4'd1;
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         de_o       <= 1'b0;
         frame      <= 1'b0;
         line       <= 1'b0;
         sx         <= '0;
         sy         <= '0;
         h_pol      <= POL_NEG;
         v_pol      <= POL_NEG;
         h_act      <= '0;
         v_act      <= '0;
         locked     <= 1'b0;
         pix_cnt    <= '0;
         line_cnt   <= '0;
         lock_cnt   <= '0;
         first_line <= 1'b0;
         line_bad   <= 1'b0;
      end else begin
         frame <= 1'b0;
         line  <= 1'b0;
         de_o  <= run_now & de_s1;

         if (de_rise) begin
            h_pol <= ~hs_s1;
            v_pol <= ~vs_s1;
         end

         if (run_now) begin
            if (de_fall) begin
               h_act <= pix_cnt;
               if (line_bad_now) begin
                  locked   <= 1'b0;
                  line_bad <= 1'b1;
               end
            end

            // The frame edge is handled before any de rise in the same cycle.
            if (vs_edge) begin
               first_line <= 1'b1;
               line_cnt   <= '0;
               line_bad   <= 1'b0;
               if (check_frame) begin
                  v_act <= line_cnt;
                  if (frame_ok) begin
                     lock_cnt <= lock_inc;
                     locked   <= (lock_inc == LOCK_N);
                  end else begin
                     lock_cnt <= '0;
                     locked   <= 1'b0;
                  end
               end
            end

            if (de_rise) begin
               sx      <= '0;
               pix_cnt <= ONE;
               line    <= 1'b1;
               if (vs_edge || first_line) begin
                  sy         <= '0;
                  frame      <= 1'b1;
                  first_line <= 1'b0;
                  line_cnt   <= ONE;
               end else begin
                  sy       <= sat_inc(sy);
                  line_cnt <= sat_inc(line_cnt);
               end
            end else if (de_s1) begin
               sx      <= sat_inc(sx);
               pix_cnt <= sat_inc(pix_cnt);
            end
         end

         if (pol_change) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx using a reduced 16x12 mode (blanking H 4/8/6, V 1/2/3).
module tb_video_timing_rx;

   localparam int CW = 8;

   logic clk_pix = 1'b0;
   logic rst_pix;
   logic hsync, vsync, de;
   logic de_o, frame, line, h_pol, v_pol, locked;
   logic signed [CW-1:0] sx, sy, h_act, v_act;

   int total = 0;
   int bad = 0;
   int last_sx = 0;
   int last_sy = 0;

   video_timing_rx #(.CORDW(CW), .H_RES(16), .V_RES(12), .LOCK_FRAMES(2)) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .hsync(hsync), .vsync(vsync), .de(de),
      .de_o(de_o), .frame(frame), .line(line), .sx(sx), .sy(sy),
      .h_pol(h_pol), .v_pol(v_pol), .h_act(h_act), .v_act(v_act), .locked(locked)
   );

   always #5 clk_pix = ~clk_pix;

   // Remember the coordinates of the most recent active output pixel.
   always @(negedge clk_pix) begin
      if (de_o === 1'b1) begin
         last_sx = int'(sx);
         last_sy = int'(sy);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic hs, input logic vs, input logic d);
      hsync = hs;
      vsync = vs;
      de    = d;
      @(posedge clk_pix);
      #1;
   endtask

   task automatic send_hblank(input logic hp, input logic vs);
      for (int i = 0; i < 4; i++) cyc(~hp, vs, 1'b0);
      for (int i = 0; i < 8; i++) cyc(hp, vs, 1'b0);
      for (int i = 0; i < 6; i++) cyc(~hp, vs, 1'b0);
   endtask

   task automatic send_line(input int w, input logic hp, input logic vs);
      for (int i = 0; i < w; i++) cyc(~hp, vs, 1'b1);
      send_hblank(hp, vs);
   endtask

   task automatic send_vhead(input logic hp, input logic vp);
      for (int i = 0; i < 2; i++) send_line(0, hp, vp);
      for (int i = 0; i < 3; i++) send_line(0, hp, ~vp);
   endtask

   task automatic send_frame(input int w, input int h, input logic hp, input logic vp);
      send_vhead(hp, vp);
      for (int i = 0; i < h; i++) send_line(w, hp, ~vp);
      send_line(0, hp, ~vp);
   endtask

   initial begin
      rst_pix = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      de    = 1'b0;
      repeat (3) @(posedge clk_pix);
      #1;
      check("rst_de_o", de_o, 0);
      check("rst_frame", frame, 0);
      check("rst_sx", sx, 0);
      check("rst_h_act", h_act, 0);
      check("rst_v_act", v_act, 0);
      check("rst_locked", locked, 0);
      @(negedge clk_pix);
      rst_pix = 1'b0;

      // Negative syncs: first frame built by hand to check the two-cycle latency.
      cyc(1, 1, 0);
      cyc(1, 1, 1);
      check("idle_de_o", de_o, 0);
      send_vhead(0, 0);
      cyc(1, 1, 1);
      check("lat1_de_o", de_o, 0);
      cyc(1, 1, 1);
      check("lat2_de_o", de_o, 1);
      check("first_frame", frame, 1);
      check("first_line", line, 1);
      check("first_sx", sx, 0);
      check("first_sy", sy, 0);
      for (int i = 0; i < 14; i++) cyc(1, 1, 1);
      send_hblank(0, 1);
      for (int i = 0; i < 11; i++) send_line(16, 0, 1);
      send_line(0, 0, 1);
      check("neg_last_sx", last_sx, 15);
      check("neg_last_sy", last_sy, 11);
      check("neg_h_act", h_act, 16);
      check("neg_h_pol", h_pol, 0);
      check("neg_v_pol", v_pol, 0);
      send_frame(16, 12, 0, 0);
      check("neg_v_act", v_act, 12);
      check("neg_lock_f1", locked, 0);
      send_frame(16, 12, 0, 0);
      check("neg_lock_f2", locked, 1);

      // One short line: lock drops exactly at that line's de fall.
      send_vhead(0, 0);
      for (int i = 0; i < 5; i++) send_line(16, 0, 1);
      for (int i = 0; i < 15; i++) cyc(1, 1, 1);
      cyc(1, 1, 0);
      check("short_pre_fall", locked, 1);
      cyc(1, 1, 0);
      check("short_locked", locked, 0);
      check("short_h_act", h_act, 15);
      send_hblank(0, 1);
      for (int i = 0; i < 6; i++) send_line(16, 0, 1);
      send_line(0, 0, 1);
      send_frame(16, 12, 0, 0);
      send_frame(16, 12, 0, 0);
      check("relock_pending", locked, 0);
      send_frame(16, 12, 0, 0);
      check("relock", locked, 1);

      // Switch to positive syncs: lock holds through the edge, drops on the next de rise.
      send_vhead(1, 1);
      check("pos_flip_hold", locked, 1);
      send_line(16, 1, 0);
      check("pos_flip_drop", locked, 0);
      for (int i = 0; i < 11; i++) send_line(16, 1, 0);
      send_line(0, 1, 0);
      send_frame(16, 12, 1, 1);
      check("pos_lock_f1", locked, 0);
      send_frame(16, 12, 1, 1);
      check("pos_lock_f2", locked, 1);
      check("pos_h_pol", h_pol, 1);
      check("pos_v_pol", v_pol, 1);

      // Mismatched 12x9 mode never locks.
      for (int i = 0; i < 3; i++) send_frame(12, 9, 1, 1);
      check("mis_h_act", h_act, 12);
      check("mis_v_act", v_act, 9);
      check("mis_locked", locked, 0);

      // vsync active edge and de rise in the same cycle.
      cyc(0, 1, 1);
      cyc(0, 1, 1);
      check("coin_de_o", de_o, 1);
      check("coin_frame", frame, 1);
      check("coin_sy", sy, 0);
      for (int i = 0; i < 14; i++) cyc(0, 1, 1);
      send_hblank(1, 1);
      send_line(16, 1, 1);
      send_line(16, 1, 1);
      send_line(0, 1, 0);
      check("coin_v_act", v_act, 3);
      check("coin_last_sy", last_sy, 2);

      // Over-long line saturates the pixel counters.
      send_line(140, 1, 0);
      check("sat_h_act", h_act, 127);
      check("sat_last_sx", last_sx, 127);

      // Asynchronous reset in the middle of a line.
      for (int i = 0; i < 10; i++) cyc(0, 0, 1);
      check("pre_rst_de_o", de_o, 1);
      check("pre_rst_sx", sx, 8);
      #2;
      rst_pix = 1'b1;
      #1;
      check("arst_de_o", de_o, 0);
      check("arst_sx", sx, 0);
      check("arst_sy", sy, 0);
      check("arst_h_act", h_act, 0);
      check("arst_v_act", v_act, 0);
      check("arst_h_pol", h_pol, 0);
      check("arst_v_pol", v_pol, 0);
      @(negedge clk_pix);
      rst_pix = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1, 1, 1);
      check("post_rst_idle", de_o, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0);
      send_vhead(0, 0);
      cyc(1, 1, 1);
      cyc(1, 1, 1);
      check("resume_de_o", de_o, 1);
      check("resume_frame", frame, 1);
      check("resume_sx", sx, 0);
      check("resume_sy", sy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_timing_rx.md
Name: video_timing_rx

Overview:
Receive-side counterpart to the display timing generators. Consumes an incoming hsync/vsync/de stream (e.g. a DVI/HDMI decoder output or loopback) and recovers screen coordinates, frame/line strobes and sync polarity. Measures active width/height per frame and flags lock when the stream matches the expected resolution. Sits between a video input front end and pixel-processing or capture logic in the same pixel clock domain.

Parameters:
CORDW, 16, signed coordinate width (bits)
H_RES, 800, expected active pixels per line
V_RES, 600, expected active lines per frame
LOCK_FRAMES, 2, consecutive matching frames required to assert locked (1..15)

Ports:
clk_pix  input  1  pixel clock
rst_pix  input  1  asynchronous active-high reset; the block's only clock is clk_pix and reset is asynchronous, active-high
hsync  input  1  incoming horizontal sync, either polarity
vsync  input  1  incoming vertical sync, either polarity
de  input  1  incoming data enable, high = active pixel
de_o  output  1  recovered data enable, aligned with sx/sy
frame  output  1  one-cycle pulse on first active pixel of frame
line  output  1  one-cycle pulse on first active pixel of each line
sx  output  CORDW  signed horizontal position, 0 on first active pixel
sy  output  CORDW  signed vertical position, 0 on first active line
h_pol  output  1  detected hsync polarity (0 neg, 1 pos)
v_pol  output  1  detected vsync polarity
h_act  output  CORDW  measured active pixels, last completed line
v_act  output  CORDW  measured active lines, last completed frame
locked  output  1  stream matches H_RES x V_RES

Behaviour:
- Reset (async): all outputs 0; state IDLE; internal counters 0; lock counter 0.
- Stage 1 registers hsync/vsync/de; edge detection compares stage 1 with its previous value. Outputs registered in stage 2: de_o(t+2) = de(t); sx/sy/frame/line align with de_o. Latency is 2 cycles.
- Polarity: on every de rising edge, h_pol <= ~hsync_s1 and v_pol <= ~vsync_s1 (sync is inactive during active video). A change in either clears locked and the lock counter.
- The vsync active edge is the transition into the level equal to v_pol.
- State IDLE: de_o, frame and line are forced 0. Move to RUN on the first vsync active edge.
- State RUN:
  - de rising: sx <= 0, line pulse, sy <= sy+1. The first line after vsync gives sy <= 0 and a frame pulse.
  - de high: sx increments each cycle.
  - de falling: h_act <= pixel count of the line just ended.
- vsync active edge in RUN:
  - v_act <= number of de lines since the previous edge.
  - If h_act == H_RES on every line and v_act == V_RES, the lock counter increments (saturating at LOCK_FRAMES) and locked asserts when the counter reaches LOCK_FRAMES.
  - Otherwise the counter clears and locked deasserts.
- Any line whose count != H_RES clears locked at that line's de falling edge, without waiting for the frame end.
- vsync active edge and de rising in the same cycle: the vsync edge is processed first, so that line is sy = 0 and frame pulses.
- Counters saturate at 2^(CORDW-1)-1 with no wrap. A saturated count forces locked = 0 at the next check.
- de high before any vsync edge (IDLE): only the polarity update occurs. There are no coordinate outputs.
- Reset mid-frame: immediate return to IDLE. Coordinates resume only after the next vsync active edge.
- h_act and v_act hold their last value between updates.

Decomposition:
- Package video_timing_pkg: state enum typedef (IDLE, RUN); POL_NEG/POL_POS constants; shared CORDW default.
- Sub-module sync_edge: a 1-bit input register plus previous-value register, with rise/fall outputs. Instantiated for hsync, vsync and de.

Test Plan:
- 800x600 stream (H 40/128/88, V 1/4/23, negative syncs) -> h_pol = 0, v_pol = 0. First pixel after first vsync gives sx = 0, sy = 0, frame = 1, two cycles after de. Last pixel gives sx = 799, sy = 599. h_act = 800, v_act = 600, locked = 1 after frame 2.
- Same stream with positive syncs -> h_pol = 1, v_pol = 1, locked after 2 frames. Flip vsync polarity mid-stream -> locked drops on the next de rise.
- Locked stream, then one line with de high for 799 cycles -> locked = 0 at that de fall, h_act = 799. Relock after 2 clean frames.
- Stream of 640x480 (H 16/96/48, V 10/2/33) -> h_act = 640, v_act = 480, locked stays 0.
- Vsync active edge coincident with de rise -> that line is sy = 0 with frame = 1. Check no extra line is counted.
- Assert rst_pix mid-line at sx = 300 -> all outputs 0 asynchronously. After release, de_o stays 0 until the next vsync edge, then sx/sy restart at 0.
